// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one word per handshake and serializes it as
// start, LSB-first data, optional parity and stop bits, each held `prescale` clocks.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk_based_on_prescale,
   input  logic                  asy_reset,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  data_valid,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  TX_OUT,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   state_t                  state_reg;
   logic [PRESCALE_W-1:0]   edge_cnt_reg;
   logic [PRESCALE_W-1:0]   last_edge_reg;
   logic [BIT_CNT_W-1:0]    bit_cnt_reg;
   logic [DATA_WIDTH-1:0]   shift_reg;
   logic                    par_en_reg;
   logic                    parity_bit_reg;
   logic                    bit_done;

   assign bit_done = (edge_cnt_reg == last_edge_reg);

   always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
      if (!asy_reset) begin
         state_reg      <= IDLE;
         edge_cnt_reg   <= '0;
         last_edge_reg  <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         par_en_reg     <= 1'b0;
         parity_bit_reg <= 1'b0;
         TX_OUT         <= 1'b1;
         busy           <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (data_valid) begin
                  // Everything the frame needs is captured here, so later
                  // input changes cannot disturb it; prescale 0 behaves as 1.
                  shift_reg      <= P_DATA;
                  par_en_reg     <= parity_enable;
                  parity_bit_reg <= (^P_DATA) ^ parity_type;
                  last_edge_reg  <= (prescale == '0) ? '0 : prescale - 1'b1;
                  edge_cnt_reg   <= '0;
                  bit_cnt_reg    <= '0;
                  state_reg      <= START;
                  TX_OUT         <= 1'b0;
                  busy           <= 1'b1;
               end
            end
            default: begin
               if (!bit_done) begin
                  edge_cnt_reg <= edge_cnt_reg + 1'b1;
               end else begin
                  edge_cnt_reg <= '0;
                  case (state_reg)
                     START: begin
                        state_reg   <= DATA;
                        bit_cnt_reg <= '0;
                        TX_OUT      <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
                     end
                     DATA: begin
                        if (bit_cnt_reg == LAST_BIT) begin
                           if (par_en_reg) begin
                              state_reg <= PARITY;
                              TX_OUT    <= parity_bit_reg;
                           end else begin
                              state_reg <= STOP;
                              TX_OUT    <= 1'b1;
                           end
                        end else begin
                           bit_cnt_reg <= bit_cnt_reg + 1'b1;
                           TX_OUT      <= shift_reg[0];
                           shift_reg   <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
                        end
                     end
                     PARITY: begin
                        state_reg <= STOP;
                        TX_OUT    <= 1'b1;
                     end
                     STOP: begin
                        state_reg <= IDLE;
                        TX_OUT    <= 1'b1;
                        busy      <= 1'b0;
                     end
                     default: begin
                        state_reg <= IDLE;
                        TX_OUT    <= 1'b1;
                        busy      <= 1'b0;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table of frames plus hand-written
// corner sequences, with a per-clock monitor fed by a scoreboard queue.
module tb_uart_tx_frame;

   logic       clk;
   logic       asy_reset;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       parity_enable;
   logic       parity_type;
   logic [5:0] prescale;
   logic       TX_OUT;
   logic       busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int frames_seen  = 0;

   uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
      .clk_based_on_prescale(clk),
      .asy_reset            (asy_reset),
      .P_DATA               (P_DATA),
      .data_valid           (data_valid),
      .parity_enable        (parity_enable),
      .parity_type          (parity_type),
      .prescale             (prescale),
      .TX_OUT               (TX_OUT),
      .busy                 (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [10:0] bits;   // line level per bit slot, slot 0 first
      int          nbits;
      int          cpb;    // clocks per bit
      logic [7:0]  data;
   } sb_t;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       pt;
      logic [5:0] ps;
      logic       exp_par;
      int         cpb;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic sb_t build(input logic [7:0] d, input logic pe, input logic par, input int cpb);
      sb_t e;
      e.bits    = '1;
      e.bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) e.bits[i+1] = d[i];
      if (pe) begin
         e.bits[9] = par;
         e.nbits   = 11;
      end else begin
         e.nbits = 10;
      end
      e.cpb  = cpb;
      e.data = d;
      return e;
   endfunction

   // Monitor: a rising busy opens a frame; every clock of it is checked.
   initial begin : monitor
      logic prev_busy;
      sb_t  e;
      int   total;
      bit   aborted;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!asy_reset) begin
            prev_busy = 1'b0;
         end else if (busy && !prev_busy) begin
            if (sb_q.size() == 0) begin
               check("unexpected_frame", 32'(busy), 32'd0);
               prev_busy = 1'b1;
            end else begin
               e = sb_q.pop_front();
               total = e.nbits * e.cpb;
               aborted = 1'b0;
               for (int k = 0; k < total; k++) begin
                  if (k > 0) @(negedge clk);
                  if (!asy_reset) begin
                     aborted = 1'b1;
                     break;
                  end
                  check("tx_bit", 32'(TX_OUT), 32'(e.bits[k / e.cpb]));
                  check("busy_in_frame", 32'(busy), 32'd1);
               end
               if (!aborted) begin
                  @(negedge clk);
                  check("busy_after_frame", 32'(busy), 32'd0);
                  check("tx_idle_after_frame", 32'(TX_OUT), 32'd1);
                  frames_seen++;
                  $display("[TB] frame data=%02h bits=%0d clocks/bit=%0d checked", e.data, e.nbits, e.cpb);
               end else begin
                  $display("[TB] frame data=%02h aborted by reset", e.data);
               end
               prev_busy = busy;
            end
         end else begin
            prev_busy = busy;
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                       input logic par, input int cpb);
      @(negedge clk);
      P_DATA = d; parity_enable = pe; parity_type = pt; prescale = ps; data_valid = 1'b1;
      sb_q.push_back(build(d, pe, par, cpb));
      @(posedge clk);
      #1 data_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || sb_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait_timeout", 32'(n < budget), 32'd1);
      @(negedge clk);
   endtask

   initial begin : stim
      int n;
      // Expected parity values are derived by hand: 0xA5 has 4 ones, 0x01 has 1.
      vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, ps: 6'd8, exp_par: 1'b0, cpb: 8};
      vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, ps: 6'd8, exp_par: 1'b0, cpb: 8};
      vecs[2] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, ps: 6'd8, exp_par: 1'b1, cpb: 8};
      vecs[3] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, ps: 6'd8, exp_par: 1'b1, cpb: 8};
      vecs[4] = '{data: 8'h01, pe: 1'b1, pt: 1'b1, ps: 6'd5, exp_par: 1'b0, cpb: 5};
      vecs[5] = '{data: 8'h81, pe: 1'b0, pt: 1'b0, ps: 6'd0, exp_par: 1'b0, cpb: 1};
      vecs[6] = '{data: 8'h81, pe: 1'b0, pt: 1'b0, ps: 6'd1, exp_par: 1'b0, cpb: 1};
      vecs[7] = '{data: 8'h6E, pe: 1'b1, pt: 1'b0, ps: 6'd3, exp_par: 1'b1, cpb: 3};

      asy_reset = 1'b0; P_DATA = '0; data_valid = 1'b0;
      parity_enable = 1'b0; parity_type = 1'b0; prescale = 6'd8;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", 32'(TX_OUT), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      asy_reset = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].ps, vecs[i].exp_par, vecs[i].cpb);
         wait_idle(400);
      end

      // Inputs disturbed and data_valid pulsed during data bit 3.
      send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 8);
      repeat (33) @(posedge clk);
      #1 P_DATA = 8'hFF; prescale = 6'd16; parity_enable = 1'b1; data_valid = 1'b1;
      @(posedge clk);
      #1 data_valid = 1'b0;
      wait_idle(400);
      repeat (20) @(negedge clk);
      check("no_queued_frame", 32'(busy), 32'd0);

      // data_valid held high: two frames with exactly one idle clock between.
      @(negedge clk);
      P_DATA = 8'h3C; parity_enable = 1'b0; parity_type = 1'b0; prescale = 6'd4; data_valid = 1'b1;
      sb_q.push_back(build(8'h3C, 1'b0, 1'b0, 4));
      @(posedge clk);
      #1 P_DATA = 8'hC3;
      sb_q.push_back(build(8'hC3, 1'b0, 1'b0, 4));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 200);
      check("b2b_first_end", 32'(busy), 32'd0);
      @(negedge clk);
      check("b2b_one_idle_gap", 32'(busy), 32'd1);
      data_valid = 1'b0;
      wait_idle(400);

      // Asynchronous reset during the parity bit, then a clean frame.
      send(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, 8);
      repeat (73) @(posedge clk);
      #2 asy_reset = 1'b0;
      #1;
      check("async_reset_tx", 32'(TX_OUT), 32'd1);
      check("async_reset_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #2 asy_reset = 1'b1;
      repeat (2) @(posedge clk);
      check("post_reset_idle", 32'(busy), 32'd0);
      send(8'h5A, 1'b0, 1'b0, 6'd4, 1'b0, 4);
      wait_idle(400);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      check("frames_completed", 32'(frames_seen), 32'd12);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

endmodule
